rf_param: RTL



---
 rtl/rf_pkg.sv | 14 +
 rtl/rf_param_if.sv | 32 +++
 rtl/rf_clear_fsm.sv | 58 +++++
 rtl/rf_param.sv | 76 +++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file definitions: datapath width defaults, clear-FSM state
// encoding and the hardwired-zero register address.
package rf_pkg;

    localparam int RF_DATA_W    = 32;
    localparam int RF_ADDR_W    = 5;
    localparam int RF_ZERO_ADDR = 0;

    // Legacy-compatible encoding: plain constants rather than an enum.
    typedef logic [0:0] rf_state_t;
    localparam rf_state_t RF_IDLE  = 1'b0;
    localparam rf_state_t RF_CLEAR = 1'b1;

endpackage

// File: rtl/rf_param_if.sv
// Register-file access bundle: two read ports, one write port, clear request
// and the busy / wr_drop status back to the pipeline.
interface rf_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();

    // No valid/ready handshake: reads are combinational and always answered,
    // a write is accepted on the edge when we=1 unless busy is high, in which
    // case it is discarded and wr_drop pulses on the following cycle.
    logic              clr_req;
    logic              busy;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic [DATA_W-1:0] qa;
    logic [DATA_W-1:0] qb;
    logic              we;
    logic [ADDR_W-1:0] rw;
    logic [DATA_W-1:0] rd;
    logic              wr_drop;

    modport master (
        output clr_req, ra, rb, we, rw, rd,
        input  busy, qa, qb, wr_drop
    );

    modport slave (
        input  clr_req, ra, rb, we, rw, rd,
        output busy, qa, qb, wr_drop
    );

endinterface

// File: rtl/rf_clear_fsm.sv
// Clear engine: walks every register address once, driving a zero-write
// strobe, after reset or on a clear request taken in IDLE.
module rf_clear_fsm
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req_i,
    output logic              busy_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o,
    output rf_state_t         state_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            RF_IDLE: begin
                if (clr_req_i) begin
                    state_d = RF_CLEAR;
                    ptr_d   = '0;
                end
            end
            RF_CLEAR: begin
                // Requests arriving mid-clear are simply ignored.
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == LAST_ADDR) begin
                    state_d = RF_IDLE;
                end
            end
            default: state_d = RF_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RF_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign busy_o     = (state_q == RF_CLEAR);
    assign clr_we_o   = (state_q == RF_CLEAR);
    assign clr_addr_o = ptr_q;
    assign state_o    = state_q;

endmodule

// File: rtl/rf_param.sv
// Parametrised 2R1W register file with hardwired-zero r0 and a clear engine.
// Define RF_BYPASS_EN to forward same-cycle write data onto matching reads.
module rf_param
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic      clk,
    input  logic      reset,
    rf_param_if.slave bus,
    output rf_state_t state_o
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_ADDR);

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              usr_we;
    logic              wr_drop_q, wr_drop_d;
    logic [DATA_W-1:0] qa_v, qb_v;

    // Storage deliberately has no reset; the clear engine zeroes it instead.
    logic [DATA_W-1:0] mem_q [DEPTH];

    rf_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk        (clk),
        .reset      (reset),
        .clr_req_i  (bus.clr_req),
        .busy_o     (busy),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .state_o    (state_o)
    );

    assign usr_we    = bus.we && (bus.rw != ZERO_ADDR) && !busy;
    assign wr_drop_d = bus.we && (bus.rw != ZERO_ADDR) && busy;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (usr_we) begin
            mem_q[bus.rw] <= bus.rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= wr_drop_d;
        end
    end

    always_comb begin
        qa_v = mem_q[bus.ra];
        qb_v = mem_q[bus.rb];
`ifdef RF_BYPASS_EN
        // usr_we already excludes r0 and busy, so bypass inherits both rules.
        if (usr_we && (bus.ra == bus.rw)) qa_v = bus.rd;
        if (usr_we && (bus.rb == bus.rw)) qb_v = bus.rd;
`endif
        if (busy || (bus.ra == ZERO_ADDR)) qa_v = '0;
        if (busy || (bus.rb == ZERO_ADDR)) qb_v = '0;
    end

    assign bus.qa      = qa_v;
    assign bus.qb      = qb_v;
    assign bus.busy    = busy;
    assign bus.wr_drop = wr_drop_q;

endmodule
